mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_pkg.sv | 22 ++
 rtl/mem_responder_if.sv | 35 +++
 rtl/mem_align.sv | 63 ++++++
 rtl/mem_responder.sv | 152 +++++++++++++++
 tb/tb_mem_responder.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// ----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the memory responder slice: access-type encodings
// used by both the lane aligner and the control FSM, and the FSM state type.
// No ports (package).
// ----------------------------------------------------------------------------
package mem_pkg;

    // Access type encodings carried on req_ctrl
    localparam logic [2:0] CTRL_B  = 3'b000;
    localparam logic [2:0] CTRL_H  = 3'b001;
    localparam logic [2:0] CTRL_W  = 3'b010;
    localparam logic [2:0] CTRL_BU = 3'b100;
    localparam logic [2:0] CTRL_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mem_responder_if.sv
// ----------------------------------------------------------------------------
// mem_responder_if
// Request/response bus between a requester (master) and the memory
// responder (slave).
//   req_valid/req_ready : request handshake
//   req_write           : 1 = store, 0 = load
//   req_ctrl            : access type (see mem_pkg)
//   req_addr            : byte address
//   req_wdata           : store data, right-aligned
//   rsp_valid/rsp_ready : response handshake
//   rsp_rdata           : extended load data, 0 for stores and errors
//   rsp_err             : access faulted
// ----------------------------------------------------------------------------
interface mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_ctrl;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_ctrl, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_ctrl, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_align.sv
// ----------------------------------------------------------------------------
// mem_align
// Combinational lane handling for one 32-bit little-endian word.
//   write     : access is a store
//   ctrl      : access type
//   lane      : addr[1:0]
//   wdata     : right-aligned store data
//   word      : current contents of the addressed word
//   ld_data   : selected lane, sign- or zero-extended to 32 bits
//   st_word   : word with the store data merged into the addressed lanes
//   align_err : illegal ctrl, misaligned H/HU/W, or store with BU/HU
// ----------------------------------------------------------------------------
module mem_align
    import mem_pkg::*;
(
    input  logic        write,
    input  logic [2:0]  ctrl,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] word,
    output logic [31:0] ld_data,
    output logic [31:0] st_word,
    output logic        align_err
);

    logic signed [7:0]  ld_byte;
    logic signed [15:0] ld_half;

    assign ld_byte = word[{lane, 3'b000} +: 8];
    assign ld_half = word[{lane[1], 4'b0000} +: 16];

    always_comb begin
        ld_data   = '0;
        st_word   = word;
        align_err = 1'b0;
        case (ctrl)
            CTRL_B: begin
                ld_data = 32'(ld_byte);
                st_word[{lane, 3'b000} +: 8] = wdata[7:0];
            end
            CTRL_BU: begin
                ld_data   = {24'b0, ld_byte};
                align_err = write;   // unsigned forms are load-only
            end
            CTRL_H: begin
                ld_data   = 32'(ld_half);
                st_word[{lane[1], 4'b0000} +: 16] = wdata[15:0];
                align_err = lane[0];
            end
            CTRL_HU: begin
                ld_data   = {16'b0, ld_half};
                align_err = lane[0] | write;
            end
            CTRL_W: begin
                ld_data   = word;
                st_word   = wdata;
                align_err = (lane != 2'b00);
            end
            default: align_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_responder.sv
// ----------------------------------------------------------------------------
// mem_responder
// Single-outstanding memory responder with fixed response latency.
//   DEPTH   : storage size in 32-bit words (>= 2)
//   LATENCY : edges from request acceptance to rsp_valid, 1..15
//   clk     : clock, rising edge
//   reset   : asynchronous, active-low
//   bus     : mem_responder_if.slave request/response bus
// The access is performed on the edge that enters RESP; the response is then
// held until the requester takes it. Storage is not reset.
// ----------------------------------------------------------------------------
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic           clk,
    input  logic           reset,
    mem_responder_if.slave bus
);

    localparam int AW = $clog2(DEPTH);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    logic        write_q;
    logic [2:0]  ctrl_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic [31:0] rdata_q;
    logic        err_q;

    logic [31:0] mem [DEPTH];

    logic        accept;
    logic        enter_resp;
    logic        acc_write;
    logic [2:0]  acc_ctrl;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [31:0] word_idx;
    logic [AW-1:0] idx;
    logic        oob;
    logic [31:0] cur_word;
    logic [31:0] ld_data;
    logic [31:0] st_word;
    logic        align_err;
    logic        acc_err;

    assign accept     = (state_q == IDLE) && bus.req_valid;
    assign enter_resp = (state_d == RESP) && (state_q != RESP);

    // With LATENCY=1 the access happens on the acceptance edge itself, so the
    // live bus is used; otherwise the captured request is used.
    always_comb begin
        if (state_q == IDLE) begin
            acc_write = bus.req_write;
            acc_ctrl  = bus.req_ctrl;
            acc_addr  = bus.req_addr;
            acc_wdata = bus.req_wdata;
        end else begin
            acc_write = write_q;
            acc_ctrl  = ctrl_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
        end
    end

    assign word_idx = {2'b00, acc_addr[31:2]};
    assign oob      = (word_idx >= 32'(DEPTH));
    assign idx      = acc_addr[AW+1:2];
    assign cur_word = oob ? '0 : mem[idx];
    assign acc_err  = align_err | oob;

    mem_align u_align (
        .write     (acc_write),
        .ctrl      (acc_ctrl),
        .lane      (acc_addr[1:0]),
        .wdata     (acc_wdata),
        .word      (cur_word),
        .ld_data   (ld_data),
        .st_word   (st_word),
        .align_err (align_err)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(LATENCY - 2);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) state_d = RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (enter_resp) begin
                err_q   <= acc_err;
                rdata_q <= (acc_err || acc_write) ? '0 : ld_data;
            end
        end
    end

    // Captured request: data only, no reset needed
    always_ff @(posedge clk) begin
        if (accept) begin
            write_q <= bus.req_write;
            ctrl_q  <= bus.req_ctrl;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
        end
    end

    // Storage: committed only for a fault-free store on RESP entry
    always_ff @(posedge clk) begin
        if (enter_resp && acc_write && !acc_err) begin
            mem[idx] <= st_word;
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_mem_responder
// Directed bench for mem_responder: one instance with LATENCY=2, one with
// LATENCY=3 (used for the reset-during-WAIT scenario). Shared stimulus
// variables are steered to the selected instance by 'sel'.
// ----------------------------------------------------------------------------
module tb_mem_responder;
    import mem_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset2;
    logic reset3;

    mem_responder_if if2 ();
    mem_responder_if if3 ();

    mem_responder #(.DEPTH(1024), .LATENCY(2)) dut2 (
        .clk   (clk),
        .reset (reset2),
        .bus   (if2.slave)
    );

    mem_responder #(.DEPTH(1024), .LATENCY(3)) dut3 (
        .clk   (clk),
        .reset (reset3),
        .bus   (if3.slave)
    );

    logic        sel;
    logic        t_valid;
    logic        t_write;
    logic        t_ready;
    logic [2:0]  t_ctrl;
    logic [31:0] t_addr;
    logic [31:0] t_wdata;

    assign if2.req_valid = t_valid & ~sel;
    assign if3.req_valid = t_valid & sel;
    assign if2.rsp_ready = t_ready & ~sel;
    assign if3.rsp_ready = t_ready & sel;
    assign if2.req_write = t_write;
    assign if3.req_write = t_write;
    assign if2.req_ctrl  = t_ctrl;
    assign if3.req_ctrl  = t_ctrl;
    assign if2.req_addr  = t_addr;
    assign if3.req_addr  = t_addr;
    assign if2.req_wdata = t_wdata;
    assign if3.req_wdata = t_wdata;

    logic        r_valid;
    logic [31:0] r_rdata;
    logic        r_err;
    assign r_valid = sel ? if3.rsp_valid : if2.rsp_valid;
    assign r_rdata = sel ? if3.rsp_rdata : if2.rsp_rdata;
    assign r_err   = sel ? if3.rsp_err   : if2.rsp_err;

    int n_tests = 0;
    int n_fail  = 0;

    // One full transaction from IDLE; lat counts edges from acceptance
    // (acceptance edge = 1) until rsp_valid is seen, capped at 20.
    task automatic xact(input logic w, input logic [2:0] c, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd,
                        output logic er, output int lat);
        @(negedge clk);
        t_valid = 1'b1;
        t_write = w;
        t_ctrl  = c;
        t_addr  = a;
        t_wdata = d;
        t_ready = 1'b0;
        @(posedge clk);
        #1;
        t_valid = 1'b0;
        lat = 1;
        while (!r_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rd = r_rdata;
        er = r_err;
        @(negedge clk);
        t_ready = 1'b1;
        @(posedge clk);
        #1;
        t_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset2 = 1'b1;
        reset3 = 1'b1;
        #2;
        reset2 = 1'b0;
        reset3 = 1'b0;
        #1;
        n_tests++; if (if2.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b exp 1", if2.req_ready); end
        n_tests++; if (if2.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b exp 0", if2.rsp_valid); end
        n_tests++; if (if2.rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_rdata got %h exp 0", if2.rsp_rdata); end
        n_tests++; if (if2.rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err got %b exp 0", if2.rsp_err); end
        repeat (3) @(negedge clk);
        reset2 = 1'b1;
        reset3 = 1'b1;
    endtask

    task automatic test_store_load();
        logic [31:0] rd;
        logic        er;
        int          lat;
        sel = 1'b0;
        xact(1'b1, CTRL_W, 32'h10, 32'hDEADBEEF, rd, er, lat);
        n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL sw_latency got %0d exp 2", lat); end
        n_tests++; if (er !== 1'b0) begin n_fail++; $display("FAIL sw_err got %b exp 0", er); end
        n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL sw_rdata got %h exp 0", rd); end
        xact(1'b0, CTRL_W, 32'h10, 32'h0, rd, er, lat);
        n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL lw_latency got %0d exp 2", lat); end
        n_tests++; if (er !== 1'b0) begin n_fail++; $display("FAIL lw_err got %b exp 0", er); end
        n_tests++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_rdata got %h exp deadbeef", rd); end
    endtask

    task automatic test_extend();
        logic [2:0]  ct  [4];
        logic [31:0] ad  [4];
        logic [31:0] ex  [4];
        logic [31:0] rd;
        logic        er;
        int          lat;
        ct[0] = CTRL_B;  ad[0] = 32'h13; ex[0] = 32'hFFFFFFDE;
        ct[1] = CTRL_BU; ad[1] = 32'h13; ex[1] = 32'h000000DE;
        ct[2] = CTRL_HU; ad[2] = 32'h12; ex[2] = 32'h0000DEAD;
        ct[3] = CTRL_H;  ad[3] = 32'h10; ex[3] = 32'hFFFFBEEF;
        sel = 1'b0;
        for (int i = 0; i < 4; i++) begin
            xact(1'b0, ct[i], ad[i], 32'h0, rd, er, lat);
            n_tests++; if (rd !== ex[i]) begin n_fail++; $display("FAIL extend_rdata[%0d] got %h exp %h", i, rd, ex[i]); end
            n_tests++; if (er !== 1'b0) begin n_fail++; $display("FAIL extend_err[%0d] got %b exp 0", i, er); end
        end
    endtask

    task automatic test_store_byte();
        logic [31:0] rd;
        logic        er;
        int          lat;
        sel = 1'b0;
        xact(1'b1, CTRL_B, 32'h11, 32'hFFFFFF55, rd, er, lat);
        n_tests++; if (er !== 1'b0) begin n_fail++; $display("FAIL sb_err got %b exp 0", er); end
        xact(1'b0, CTRL_W, 32'h10, 32'h0, rd, er, lat);
        n_tests++; if (rd !== 32'hDEAD55EF) begin n_fail++; $display("FAIL sb_readback got %h exp dead55ef", rd); end
    endtask

    task automatic test_errors();
        logic        wr  [8];
        logic [2:0]  ct  [8];
        logic [31:0] ad  [8];
        logic [31:0] rd;
        logic        er;
        int          lat;
        wr[0] = 1'b0; ct[0] = CTRL_W;  ad[0] = 32'h12;
        wr[1] = 1'b1; ct[1] = CTRL_H;  ad[1] = 32'h13;
        wr[2] = 1'b0; ct[2] = 3'b011;  ad[2] = 32'h10;
        wr[3] = 1'b0; ct[3] = CTRL_W;  ad[3] = 32'h1000;
        wr[4] = 1'b1; ct[4] = CTRL_BU; ad[4] = 32'h10;
        wr[5] = 1'b1; ct[5] = CTRL_W;  ad[5] = 32'h11;
        wr[6] = 1'b1; ct[6] = CTRL_W;  ad[6] = 32'h1010;
        wr[7] = 1'b1; ct[7] = 3'b011;  ad[7] = 32'h10;
        sel = 1'b0;
        for (int i = 0; i < 8; i++) begin
            xact(wr[i], ct[i], ad[i], 32'hA5A5A5A5, rd, er, lat);
            n_tests++; if (er !== 1'b1) begin n_fail++; $display("FAIL err_flag[%0d] got %b exp 1", i, er); end
            n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL err_rdata[%0d] got %h exp 0", i, rd); end
            n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL err_latency[%0d] got %0d exp 2", i, lat); end
        end
        xact(1'b0, CTRL_W, 32'h10, 32'h0, rd, er, lat);
        n_tests++; if (rd !== 32'hDEAD55EF) begin n_fail++; $display("FAIL err_unchanged got %h exp dead55ef", rd); end
        n_tests++; if (er !== 1'b0) begin n_fail++; $display("FAIL err_clear got %b exp 0", er); end
    endtask

    task automatic test_backpressure();
        int cyc;
        sel = 1'b0;
        @(negedge clk);
        t_valid = 1'b1;
        t_write = 1'b0;
        t_ctrl  = CTRL_W;
        t_addr  = 32'h10;
        t_wdata = 32'h0;
        t_ready = 1'b0;
        @(posedge clk);
        #1;
        t_valid = 1'b0;
        cyc = 0;
        while (!if2.rsp_valid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        n_tests++; if (cyc >= 20) begin n_fail++; $display("FAIL bp_rsp_seen got timeout exp rsp_valid"); end
        for (int i = 0; i < 5; i++) begin
            n_tests++; if (if2.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d] got %b exp 1", i, if2.rsp_valid); end
            n_tests++; if (if2.rsp_rdata !== 32'hDEAD55EF) begin n_fail++; $display("FAIL bp_rdata[%0d] got %h exp dead55ef", i, if2.rsp_rdata); end
            n_tests++; if (if2.rsp_err !== 1'b0) begin n_fail++; $display("FAIL bp_err[%0d] got %b exp 0", i, if2.rsp_err); end
            n_tests++; if (if2.req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_req_ready[%0d] got %b exp 0", i, if2.req_ready); end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        t_ready = 1'b1;
        @(posedge clk);
        #1;
        t_ready = 1'b0;
        n_tests++; if (if2.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_after_valid got %b exp 0", if2.rsp_valid); end
        n_tests++; if (if2.req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_after_ready got %b exp 1", if2.req_ready); end
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] rd;
        logic        er;
        int          lat;
        sel = 1'b1;
        xact(1'b1, CTRL_W, 32'h20, 32'h0BADF00D, rd, er, lat);
        n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL l3_sw_latency got %0d exp 3", lat); end
        xact(1'b0, CTRL_W, 32'h20, 32'h0, rd, er, lat);
        n_tests++; if (rd !== 32'h0BADF00D) begin n_fail++; $display("FAIL l3_lw_rdata got %h exp 0badf00d", rd); end
        // Start a store, then reset while it is waiting
        @(negedge clk);
        t_valid = 1'b1;
        t_write = 1'b1;
        t_ctrl  = CTRL_W;
        t_addr  = 32'h20;
        t_wdata = 32'h12345678;
        t_ready = 1'b0;
        @(posedge clk);
        #1;
        t_valid = 1'b0;
        n_tests++; if (if3.req_ready !== 1'b0) begin n_fail++; $display("FAIL l3_wait_ready got %b exp 0", if3.req_ready); end
        @(negedge clk);
        reset3 = 1'b0;
        #1;
        n_tests++; if (if3.req_ready !== 1'b1) begin n_fail++; $display("FAIL rstw_req_ready got %b exp 1", if3.req_ready); end
        n_tests++; if (if3.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rstw_rsp_valid got %b exp 0", if3.rsp_valid); end
        n_tests++; if (if3.rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL rstw_rsp_rdata got %h exp 0", if3.rsp_rdata); end
        n_tests++; if (if3.rsp_err !== 1'b0) begin n_fail++; $display("FAIL rstw_rsp_err got %b exp 0", if3.rsp_err); end
        repeat (3) @(negedge clk);
        reset3 = 1'b1;
        n_tests++; if (if3.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rstw_dropped got %b exp 0", if3.rsp_valid); end
        xact(1'b0, CTRL_W, 32'h20, 32'h0, rd, er, lat);
        n_tests++; if (rd !== 32'h0BADF00D) begin n_fail++; $display("FAIL rstw_not_committed got %h exp 0badf00d", rd); end
        n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL rstw_latency got %0d exp 3", lat); end
    endtask

    initial begin
        sel     = 1'b0;
        t_valid = 1'b0;
        t_write = 1'b0;
        t_ready = 1'b0;
        t_ctrl  = 3'b000;
        t_addr  = 32'h0;
        t_wdata = 32'h0;
        test_reset();
        test_store_load();
        test_extend();
        test_store_byte();
        test_errors();
        test_backpressure();
        test_reset_in_wait();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout got no finish exp finish");
        $fatal(1, "timeout");
    end

endmodule
